// File: rtl/fault_inj_sched.sv
// ---------------------------------------------------------------------------
// fault_inj_sched
// Campaign scheduler for the TMR fault-injection path. A campaign runs a
// programmed number of single-bit upsets. The upsets are applied to the three
// core replicas in round-robin order. For every upset the scheduler:
//   1. idles for a gap,
//   2. drives inj_en/inj_data for hold cycles,
//   3. observes the voter flags for a settle window,
//   4. logs whether the fault was detected (voter_mismatch) and/or escaped
//      (voter_err).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      campaign control (start sampled only in IDLE)
//   num_inj, gap, hold, settle, seed
//                     campaign configuration, latched on an accepted start
//   ref_counter       golden (voted) counter value that the upset corrupts
//   voter_mismatch    replicas disagree
//   voter_err         voted output differs from golden
//   inj_en            one-hot replica injection enable (bit i -> replica i)
//   inj_data          ref_counter with one bit flipped while injecting, else 0
//   busy, done        busy outside IDLE; done is a one-cycle completion pulse
//   inj_count, detected_count, escaped_count
//                     saturating campaign tallies
//   state_dbg         current FSM state encoding, for checkers
//
// Handshake: start is a level sampled on the rising edge while IDLE. It is
// accepted only when abort is low in the same cycle. abort is sampled every
// cycle and wins over all other activity outside IDLE.
// ---------------------------------------------------------------------------
module fault_inj_sched #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [7:0]   num_inj,
   input  logic [7:0]   gap,
   input  logic [3:0]   hold,
   input  logic [3:0]   settle,
   input  logic [7:0]   seed,
   input  logic [W-1:0] ref_counter,
   input  logic         voter_mismatch,
   input  logic         voter_err,
   output logic [2:0]   inj_en,
   output logic [W-1:0] inj_data,
   output logic         busy,
   output logic         done,
   output logic [7:0]   inj_count,
   output logic [7:0]   detected_count,
   output logic [7:0]   escaped_count,
   output logic [2:0]   state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GAP    = 3'd1,
      S_INJECT = 3'd2,
      S_SETTLE = 3'd3,
      S_LOG    = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t      state;
   logic [7:0]  num_l;
   logic [7:0]  gap_l;
   logic [3:0]  hold_l;      // already forced to >= 1
   logic [3:0]  settle_l;
   logic [7:0]  lfsr;
   logic [1:0]  ptr;
   logic [7:0]  cnt;         // cycles spent in the current timed state
   logic        det_flag;
   logic        esc_flag;

   logic [W-1:0] mask;
   logic [7:0]   lfsr_next;
   logic [7:0]   inj_count_inc;

   // Galois LFSR step: right shift, taps 0xB8.
   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);

   // The LFSR has already advanced on GAP exit, so its low bits select the
   // bit to flip for the whole INJECT phase.
   assign mask = {{(W-1){1'b0}}, 1'b1} << lfsr[2:0];

   function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
      return (en && (v != 8'hFF)) ? (v + 8'd1) : v;
   endfunction

   assign inj_count_inc = sat_inc(inj_count, 1'b1);

   // Outputs decoded straight from state registers. An abort takes effect at
   // the next edge. A reset clears state asynchronously, so both remove inj_en
   // without extra logic.
   always_comb begin
      inj_en   = 3'b000;
      inj_data = '0;
      if (state == S_INJECT) begin
         case (ptr)
            2'd0:    inj_en = 3'b001;
            2'd1:    inj_en = 3'b010;
            default: inj_en = 3'b100;
         endcase
         inj_data = ref_counter ^ mask;
      end
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         num_l          <= 8'd0;
         gap_l          <= 8'd0;
         hold_l         <= 4'd1;
         settle_l       <= 4'd0;
         lfsr           <= 8'h01;
         ptr            <= 2'd0;
         cnt            <= 8'd0;
         det_flag       <= 1'b0;
         esc_flag       <= 1'b0;
         inj_count      <= 8'd0;
         detected_count <= 8'd0;
         escaped_count  <= 8'd0;
      end else if ((state != S_IDLE) && abort) begin
         // Abandon: counters, LFSR and pointer keep their values.
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  num_l          <= num_inj;
                  gap_l          <= gap;
                  hold_l         <= (hold == 4'd0) ? 4'd1 : hold;
                  settle_l       <= settle;
                  lfsr           <= (seed == 8'd0) ? 8'h01 : seed;
                  ptr            <= 2'd0;
                  cnt            <= 8'd0;
                  det_flag       <= 1'b0;
                  esc_flag       <= 1'b0;
                  inj_count      <= 8'd0;
                  detected_count <= 8'd0;
                  escaped_count  <= 8'd0;
                  state          <= (num_inj == 8'd0) ? S_DONE : S_GAP;
               end
            end
            S_GAP: begin
               if (cnt == gap_l) begin
                  lfsr  <= lfsr_next;
                  cnt   <= 8'd0;
                  state <= S_INJECT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_INJECT: begin
               det_flag <= det_flag | voter_mismatch;
               esc_flag <= esc_flag | voter_err;
               if (cnt == {4'd0, hold_l - 4'd1}) begin
                  cnt   <= 8'd0;
                  state <= S_SETTLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_SETTLE: begin
               det_flag <= det_flag | voter_mismatch;
               esc_flag <= esc_flag | voter_err;
               if (cnt == {4'd0, settle_l}) begin
                  cnt   <= 8'd0;
                  state <= S_LOG;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_LOG: begin
               inj_count      <= inj_count_inc;
               detected_count <= sat_inc(detected_count, det_flag);
               escaped_count  <= sat_inc(escaped_count, esc_flag);
               ptr            <= (ptr == 2'd2) ? 2'd0 : (ptr + 2'd1);
               cnt            <= 8'd0;
               // Clearing here is the same as clearing on GAP entry.
               det_flag       <= 1'b0;
               esc_flag       <= 1'b0;
               state          <= (inj_count_inc == num_l) ? S_DONE : S_GAP;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
